fdtd_hy_update: RTL

Hy field update engine for the 1-D FDTD accelerator. It sits between the field buffer's previous-timestep RAMs and its current-timestep RAMs. It streams Hy_old[i] and Ez_old[i], Ez_old[i+1] out of the buffer's read ports and computes Hy_n[i] = Hy_old[i] + ((coef × (Ez_old[i+1] − Ez_old[i])) >>> FRAC_WIDTH) with saturation. It writes Hy_n[i] back through the buffer's Hy_n write port and pulses done when the last cell has been committed.

---
 rtl/fdtd_pkg.sv | 34 +++
 rtl/fdtd_coef_mul.sv | 30 +++
 rtl/fdtd_hy_update.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fdtd_pkg.sv
// Shared FDTD types, constants and the signed saturation helper.
// Used by the Hy and Ez update engines.
package fdtd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } hy_state_e;

  localparam int HY_UPD_LATENCY = 3;
  localparam int SAT_IN_W  = 128;
  localparam int SAT_OUT_W = 64;

  // Clamp a wide signed value to the signed w-bit range.
  function automatic logic [SAT_OUT_W-1:0] sat_s(
    input logic signed [SAT_IN_W-1:0] x,
    input int w
  );
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi = (SAT_IN_W'(1) <<< (w - 1)) - SAT_IN_W'(1);
    lo = ~hi;
    if (x > hi)
      sat_s = hi[SAT_OUT_W-1:0];
    else if (x < lo)
      sat_s = lo[SAT_OUT_W-1:0];
    else
      sat_s = x[SAT_OUT_W-1:0];
  endfunction

endpackage

// File: rtl/fdtd_coef_mul.sv
// Registered coef x diff multiply, floor shift and saturate.
// Shared between the Hy and Ez update engines.
module fdtd_coef_mul #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic signed [W-1:0] coef_i,
  input  logic signed [W:0]   diff_i,
  output logic signed [W-1:0] delta_o
);
  import fdtd_pkg::*;

  localparam int PW = 2 * W + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shr;

  assign prod = PW'(coef_i) * PW'(diff_i);
  assign shr  = prod >>> FRAC;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      delta_o <= '0;
    else
      delta_o <= W'(sat_s(SAT_IN_W'(shr), W));
  end

endmodule

// File: rtl/fdtd_hy_update.sv
// Hy field update engine: streams Hy_old/Ez_old, writes saturated Hy_n.
// Read issue to write is HY_UPD_LATENCY cycles, one cell per cycle.
module fdtd_hy_update #(
  parameter int FDTD_DATA_WIDTH   = 32,
  parameter int BUFFER_ADDR_WIDTH = 6,
  parameter int FRAC_WIDTH        = 16
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         start_i,
  input  logic [BUFFER_ADDR_WIDTH-1:0] size_i,
  input  logic [FDTD_DATA_WIDTH-1:0]   coef_i,
  output logic                         rd_Hy_old_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] rd_Hy_old_addr_o,
  output logic                         rd_Ez_old_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] rd_Ez_old_addr_o,
  input  logic [FDTD_DATA_WIDTH-1:0]   Hy_old_i,
  input  logic [FDTD_DATA_WIDTH-1:0]   Ez_old_i,
  output logic                         wrt_Hy_n_en_o,
  output logic [BUFFER_ADDR_WIDTH-1:0] wrt_Hy_n_addr_o,
  output logic [FDTD_DATA_WIDTH-1:0]   Hy_n_o,
  output logic                         busy_o,
  output logic                         done_o
);
  import fdtd_pkg::*;

  localparam int W = FDTD_DATA_WIDTH;
  localparam int A = BUFFER_ADDR_WIDTH;

  hy_state_e            state;
  logic [A-1:0]         cnt;
  logic [A-1:0]         n_q;
  logic signed [W-1:0]  coef_q;

  logic                 ez_v;
  logic [W-1:0]         ez_prev;
  logic                 in_v;
  logic [A-1:0]         in_addr;
  logic                 b_v;
  logic [A-1:0]         b_addr;
  logic [W-1:0]         b_hy;
  logic signed [W-1:0]  delta;
  logic signed [W:0]    diff;
  logic signed [W:0]    sum;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      n_q    <= '0;
      coef_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start_i) begin
          n_q    <= size_i;
          coef_q <= coef_i;
          cnt    <= '0;
          state  <= (size_i == '0) ? ST_DONE : ST_PRIME;
        end
        ST_PRIME: begin
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (cnt == n_q - 1'b1) begin
            cnt   <= '0;
            state <= ST_DRAIN;
          end else
            cnt <= cnt + 1'b1;
        end
        ST_DRAIN: begin
          if (cnt == A'(HY_UPD_LATENCY - 1))
            state <= ST_DONE;
          else
            cnt <= cnt + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rd_Hy_old_en_o   = (state == ST_RUN);
  assign rd_Hy_old_addr_o = rd_Hy_old_en_o ? cnt : '0;
  assign rd_Ez_old_en_o   = (state == ST_PRIME) || rd_Hy_old_en_o;
  assign rd_Ez_old_addr_o = rd_Hy_old_en_o ? cnt + 1'b1 : '0;
  assign busy_o = (state == ST_PRIME) || (state == ST_RUN) ||
                  (state == ST_DRAIN);
  assign done_o = (state == ST_DONE);

  // Stage A is combinational on the RAM data; stage B registers it.
  assign diff = $signed({Ez_old_i[W-1], Ez_old_i})
              - $signed({ez_prev[W-1], ez_prev});

  fdtd_coef_mul #(
    .W    (W),
    .FRAC (FRAC_WIDTH)
  ) u_mul (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .coef_i  (coef_q),
    .diff_i  (diff),
    .delta_o (delta)
  );

  assign sum = $signed({b_hy[W-1], b_hy})
             + $signed({delta[W-1], delta});

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ez_v            <= 1'b0;
      ez_prev         <= '0;
      in_v            <= 1'b0;
      in_addr         <= '0;
      b_v             <= 1'b0;
      b_addr          <= '0;
      b_hy            <= '0;
      wrt_Hy_n_en_o   <= 1'b0;
      wrt_Hy_n_addr_o <= '0;
      Hy_n_o          <= '0;
    end else begin
      ez_v    <= rd_Ez_old_en_o;
      in_v    <= rd_Hy_old_en_o;
      in_addr <= rd_Hy_old_addr_o;
      if (ez_v)
        ez_prev <= Ez_old_i;
      b_v    <= in_v;
      b_addr <= in_addr;
      b_hy   <= Hy_old_i;
      wrt_Hy_n_en_o   <= b_v;
      wrt_Hy_n_addr_o <= b_addr;
      Hy_n_o          <= W'(sat_s(SAT_IN_W'(sum), W));
    end
  end

endmodule
